// File: rtl/fmul_share_arbiter.sv
// fmul_share_arbiter: round-robin arbiter that time-shares one float64_mul
// core (ap_start/ap_ready/ap_done handshake) between NUM_REQ requesters.
// One operation is in flight at a time. The winner's operands are captured into
// mul_a/mul_b, the core is started, and the result is routed back to the
// winner with a one-cycle rsp_valid pulse.
// Optional build macro FMUL_ARB_STATS_EN adds per-requester completed-op
// counters (op_count) and a busy-cycle counter (busy_cycles).
module fmul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int KEY_W   = 18
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
`ifdef FMUL_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]     op_count,
  output logic [31:0]               busy_cycles,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      mul_ap_start,
  input  logic                      mul_ap_ready,
  input  logic                      mul_ap_done,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_ap_return,
  input  logic [KEY_W-1:0]          working_key_in,
  output logic [KEY_W-1:0]          working_key
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_next;
  logic [GW-1:0]     grant, last_grant, winner, cand;
  logic              found;
  logic              do_grant, do_resp;
  logic [DATA_W-1:0] sel_a, sel_b;

  assign busy        = (state != IDLE);
  assign working_key = working_key_in;

  // Round-robin search: first requester above last_grant, wrapping around.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves a value held and a latch is inferred.
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Operand mux selecting the winner's slot from the packed request buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == winner) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic: grant in IDLE, wait for ready in ISSUE, done in WAIT.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mul_ap_ready) begin
          if (mul_ap_done) begin
            do_resp    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mul_ap_done) begin
          do_resp    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  // Datapath: operand capture, grant bookkeeping, start and response pulses.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      req_ack      <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      mul_ap_start <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      grant        <= '0;
      last_grant   <= GW'(NUM_REQ - 1);
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      if (do_grant) begin
        mul_a        <= sel_a;
        mul_b        <= sel_b;
        grant        <= winner;
        last_grant   <= winner;
        req_ack      <= NUM_REQ'(1) << winner;
        mul_ap_start <= 1'b1;
      end
      // Start is held until the core has accepted the operands.
      if (state == ISSUE && mul_ap_ready) mul_ap_start <= 1'b0;
      if (do_resp) begin
        rsp_data  <= mul_ap_return;
        rsp_valid <= NUM_REQ'(1) << grant;
      end
    end
  end

`ifdef FMUL_ARB_STATS_EN
  // Free-running statistics: wrap at max, cleared only by reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (busy) busy_cycles <= busy_cycles + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i]) op_count[i*16 +: 16] <= op_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
